pic_inta_sequencer: RTL and testbench
=====================================

Name: pic_inta_sequencer

Overview:
- Interrupt acknowledge sequencer and priority resolver for the 8259 PIC. Sits between the IRR block and the control/data-bus logic.
- Compares unmasked IRR requests against the In-Service Register (ISR) it owns, and raises INT.
- Runs the two-pulse 8086-mode INTA cycle: freezes the winning level, sets its ISR bit, tells IRR which bit to clear, and drives the vector on the second pulse.
- Processes EOI commands, including specific, non-specific, automatic and rotating variants.

Parameters:
- INIT_LOWEST, 7: lowest-priority level loaded at reset (3-bit value).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- irr  input  8  request bits from the IRR block
- imr  input  8  interrupt mask; 1 masks the level
- inta_n  input  1  CPU acknowledge, active low, already synchronised to clk
- vector_base  input  5  ICW2 bits T7..T3
- aeoi  input  1  automatic EOI mode enable
- eoi_strobe  input  1  one-cycle pulse: OCW2 EOI command
- eoi_specific  input  1  qualifies eoi_strobe: 1 = specific EOI
- eoi_level  input  3  level for a specific EOI
- rotate  input  1  qualifies eoi_strobe and AEOI: rotate priority on clear
- int_out  output  1  INT to the CPU
- isr  output  8  In-Service Register
- clear_valid  output  1  one-cycle pulse: IRR must clear clear_level
- clear_level  output  3  level to clear in IRR
- inta_count  output  2  INTA pulses seen in the current cycle (0..2)
- data_out  output  8  vector byte
- data_oe  output  1  data_out valid / bus drive enable

Behaviour:
- Reset:
  - isr=0, int_out=0, clear_valid=0, clear_level=0, inta_count=0, data_out=0, data_oe=0.
  - lowest=INIT_LOWEST; state=IDLE; inta_prev=1.
  - Reset mid-cycle aborts the cycle; ISR bits are not preserved.
- Priority:
  - Level k has rank (k - lowest - 1) mod 8; rank 0 is highest.
  - Candidate = highest-rank bit of irr & ~imr.
  - isr_top = highest-rank bit of isr.
- int_out:
  - Registered; 1 in IDLE when a candidate exists and its rank is strictly better than isr_top, or isr is empty.
  - Otherwise 0. The 1-cycle latency from an irr change is required.
- Edge detect:
  - inta_prev is the registered copy of inta_n.
  - fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
- States:
  - IDLE -> ACK1 on fall.
    - Latch win_level = candidate.
    - If no candidate: spurious=1 and win_level=7.
    - inta_count=1.
  - ACK1, next cycle:
    - If not spurious, set isr[win_level] and pulse clear_valid with clear_level=win_level for exactly 1 cycle.
    - Stay in ACK1 until the next fall.
  - ACK1 -> ACK2 on fall: inta_count=2; data_out={vector_base, win_level}; data_oe=1.
  - ACK2 -> IDLE on rise:
    - data_oe=0; inta_count=0.
    - If aeoi and not spurious, clear isr[win_level]. If rotate is also set, lowest=win_level.
- int_out is held 0 in ACK1/ACK2.
- irr/imr changes after the first fall do not alter win_level.
- EOI (eoi_strobe) is accepted in any state:
  - Non-specific: clear isr_top. If rotate, lowest=that level. No-op if isr==0.
  - Specific: clear isr[eoi_level]. If rotate, lowest=eoi_level.
  - EOI is evaluated against ISR before any same-cycle set. If an EOI and the ACK1 set target the same bit, the set wins.
- inta_n held low across several cycles counts as one pulse. A fall while in ACK2 is ignored.

Test Plan:
- After reset, drive irr=8'b0010_0100, imr=0. -> int_out=1 one cycle later. On the 1st INTA: isr=8'b0000_0100, clear_valid pulse with clear_level=2. On the 2nd INTA: data_oe=1 and data_out={vector_base,3'd2} (base 5'h08 -> 8'h42).
- imr=8'b0000_0100 with the same irr. -> winner is level 5, isr=8'b0010_0000, data_out=8'h45.
- With isr[2] set, irr gains bit 1 -> int_out=1. irr gains bit 4 instead -> int_out stays 0. Non-specific EOI -> isr=0.
- aeoi=1, rotate=1, irr=8'b0000_1000, full INTA cycle. -> isr returns to 0 on the 2nd INTA rise, lowest=3. Then irr=8'b0001_1000 -> level 4 wins.
- irr drops to 0 before the 1st INTA fall. -> spurious cycle: isr unchanged, no clear_valid pulse, data_out={base,3'd7}.
- Assert reset while in ACK1 with isr[0] set. -> the cycle after, every output is 0 and the 2nd INTA pulse produces no data_oe.

Source files
------------

// File: rtl/pic_inta_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic_inta_sequencer_if : request/acknowledge/EOI/vector bundle for the 8259 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pic_inta_sequencer_if;
   logic [7:0] irr;
   logic [7:0] imr;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       aeoi;
   logic       eoi_strobe;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       rotate;
   logic       int_out;
   logic [7:0] isr;
   logic       clear_valid;
   logic [2:0] clear_level;
   logic [1:0] inta_count;
   logic [7:0] data_out;
   logic       data_oe;

   modport slave (
      input  irr, imr, inta_n, vector_base, aeoi, eoi_strobe, eoi_specific, eoi_level, rotate,
      output int_out, isr, clear_valid, clear_level, inta_count, data_out, data_oe
   );

   modport master (
      output irr, imr, inta_n, vector_base, aeoi, eoi_strobe, eoi_specific, eoi_level, rotate,
      input  int_out, isr, clear_valid, clear_level, inta_count, data_out, data_oe
   );
endinterface
`default_nettype wire

// File: rtl/pic_inta_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic_inta_sequencer : 8259 priority resolver, ISR owner and INTA sequencer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pic_inta_sequencer #(
   parameter logic [2:0] INIT_LOWEST = 3'd7
) (
   input logic                 clk,
   input logic                 reset,
   pic_inta_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK1 = 2'd1,
      S_ACK2 = 2'd2
   } state_t;

   // Returns {found, rank[2:0], level[2:0]} of the highest-priority set bit.
   function automatic logic [6:0] find_top(input logic [7:0] v, input logic [2:0] low);
      logic [2:0] lvl;
      logic [6:0] res;
      res = '0;
      for (int r = 7; r >= 0; r--) begin
         lvl = low + 3'd1 + 3'(r);
         if (v[lvl]) res = {1'b1, 3'(r), lvl};
      end
      return res;
   endfunction

   state_t     state_q, state_d;
   logic       inta_prev_q;
   logic [2:0] win_q, win_d;
   logic       spur_q, spur_d;
   logic       set_pend_q, set_pend_d;
   logic [7:0] isr_q, isr_d;
   logic [2:0] lowest_q, lowest_d;
   logic       int_out_q, int_out_d;
   logic       clear_valid_q, clear_valid_d;
   logic [2:0] clear_level_q, clear_level_d;
   logic [1:0] count_q, count_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_oe_q, data_oe_d;

   logic [6:0] cand;
   logic [6:0] top;
   logic       fall;
   logic       rise;

   assign cand = find_top(bus.irr & ~bus.imr, lowest_q);
   assign top  = find_top(isr_q, lowest_q);
   assign fall = inta_prev_q & ~bus.inta_n;
   assign rise = ~inta_prev_q & bus.inta_n;

   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      spur_d        = spur_q;
      set_pend_d    = 1'b0;
      isr_d         = isr_q;
      lowest_d      = lowest_q;
      clear_valid_d = 1'b0;
      clear_level_d = clear_level_q;
      count_d       = count_q;
      data_out_d    = data_out_q;
      data_oe_d     = data_oe_q;

      // EOI sees the ISR as it stood at the start of the cycle.
      if (bus.eoi_strobe) begin
         if (bus.eoi_specific) begin
            isr_d[bus.eoi_level] = 1'b0;
            if (bus.rotate) lowest_d = bus.eoi_level;
         end else if (top[6]) begin
            isr_d[top[2:0]] = 1'b0;
            if (bus.rotate) lowest_d = top[2:0];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_ACK1;
               count_d = 2'd1;
               if (cand[6]) begin
                  win_d      = cand[2:0];
                  spur_d     = 1'b0;
                  set_pend_d = 1'b1;
               end else begin
                  win_d  = 3'd7;
                  spur_d = 1'b1;
               end
            end
         end
         S_ACK1: begin
            if (fall) begin
               state_d    = S_ACK2;
               count_d    = 2'd2;
               data_out_d = {bus.vector_base, win_q};
               data_oe_d  = 1'b1;
            end
         end
         S_ACK2: begin
            if (rise) begin
               state_d   = S_IDLE;
               count_d   = 2'd0;
               data_oe_d = 1'b0;
               if (bus.aeoi && !spur_q) begin
                  isr_d[win_q] = 1'b0;
                  if (bus.rotate) lowest_d = win_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The ACK1 set is applied last so it overrides a same-cycle EOI clear.
      if (set_pend_q) begin
         isr_d[win_q]  = 1'b1;
         clear_valid_d = 1'b1;
         clear_level_d = win_q;
      end

      int_out_d = (state_d == S_IDLE) && cand[6] && (!top[6] || (cand[5:3] < top[5:3]));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         inta_prev_q   <= 1'b1;
         win_q         <= 3'd0;
         spur_q        <= 1'b0;
         set_pend_q    <= 1'b0;
         isr_q         <= 8'd0;
         lowest_q      <= INIT_LOWEST;
         int_out_q     <= 1'b0;
         clear_valid_q <= 1'b0;
         clear_level_q <= 3'd0;
         count_q       <= 2'd0;
         data_out_q    <= 8'd0;
         data_oe_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         inta_prev_q   <= bus.inta_n;
         win_q         <= win_d;
         spur_q        <= spur_d;
         set_pend_q    <= set_pend_d;
         isr_q         <= isr_d;
         lowest_q      <= lowest_d;
         int_out_q     <= int_out_d;
         clear_valid_q <= clear_valid_d;
         clear_level_q <= clear_level_d;
         count_q       <= count_d;
         data_out_q    <= data_out_d;
         data_oe_q     <= data_oe_d;
      end
   end

   assign bus.int_out     = int_out_q;
   assign bus.isr         = isr_q;
   assign bus.clear_valid = clear_valid_q;
   assign bus.clear_level = clear_level_q;
   assign bus.inta_count  = count_q;
   assign bus.data_out    = data_out_q;
   assign bus.data_oe     = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_inta_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pic_inta_sequencer : directed scoreboard bench for pic_inta_sequencer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pic_inta_sequencer;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   logic [2:0] clr_q[$];
   logic [7:0] vec_q[$];

   pic_inta_sequencer_if bus ();

   pic_inta_sequencer #(
      .INIT_LOWEST(3'd7)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT emits a clear pulse or a vector.
   initial begin
      logic oe_prev;
      oe_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.clear_valid) begin
               if (clr_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL clear_unexpected: got level %0d expected no pulse", bus.clear_level);
               end else begin
                  chk("clear_level", {5'd0, bus.clear_level}, {5'd0, clr_q.pop_front()});
               end
            end
            if (bus.data_oe && !oe_prev) begin
               if (vec_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL vector_unexpected: got %h expected no drive", bus.data_out);
               end else begin
                  chk("vector", bus.data_out, vec_q.pop_front());
               end
            end
         end
         oe_prev = bus.data_oe;
      end
   end

   // One full two-pulse acknowledge; the bench plays the IRR block and clears the won bit.
   task automatic ack_cycle(input logic [2:0] lvl, input bit spur, input logic [7:0] isr_after1);
      if (!spur) clr_q.push_back(lvl);
      vec_q.push_back({bus.vector_base, (spur ? 3'd7 : lvl)});
      bus.inta_n = 1'b0;
      tick();
      chk("count_ack1", {6'd0, bus.inta_count}, 8'd1);
      chk("int_ack1", {7'd0, bus.int_out}, 8'd0);
      tick();
      bus.inta_n = 1'b1;
      tick();
      chk("isr_after_ack1", bus.isr, isr_after1);
      chk("clear_one_cycle", {7'd0, bus.clear_valid}, 8'd0);
      if (!spur) bus.irr[lvl] = 1'b0;
      bus.inta_n = 1'b0;
      tick();
      chk("count_ack2", {6'd0, bus.inta_count}, 8'd2);
      bus.inta_n = 1'b1;
      tick();
      chk("oe_released", {7'd0, bus.data_oe}, 8'd0);
      chk("count_idle", {6'd0, bus.inta_count}, 8'd0);
   endtask

   task automatic eoi(input bit specific, input logic [2:0] lvl, input bit rot);
      bus.eoi_strobe   = 1'b1;
      bus.eoi_specific = specific;
      bus.eoi_level    = lvl;
      bus.rotate       = rot;
      tick();
      bus.eoi_strobe   = 1'b0;
      bus.eoi_specific = 1'b0;
      bus.rotate       = 1'b0;
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      reset            = 1'b1;
      bus.irr          = 8'h00;
      bus.imr          = 8'h00;
      bus.inta_n       = 1'b1;
      bus.vector_base  = 5'h08;
      bus.aeoi         = 1'b0;
      bus.eoi_strobe   = 1'b0;
      bus.eoi_specific = 1'b0;
      bus.eoi_level    = 3'd0;
      bus.rotate       = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {bus.int_out, bus.clear_valid, bus.data_oe, bus.inta_count, bus.clear_level}, 8'd0);
      chk("reset_isr", bus.isr, 8'h00);
      chk("reset_data", bus.data_out, 8'h00);
      reset = 1'b0;

      // Lowest level wins with the reset priority order.
      bus.irr = 8'b0010_0100;
      tick();
      chk("int_latency", {7'd0, bus.int_out}, 8'd1);
      ack_cycle(3'd2, 1'b0, 8'b0000_0100);
      chk("int_blocked_by_isr", {7'd0, bus.int_out}, 8'd0);
      eoi(1'b0, 3'd0, 1'b0);
      chk("nseoi_clear", bus.isr, 8'h00);

      // Masked level 2 lets level 5 win.
      bus.imr = 8'b0000_0100;
      bus.irr = 8'b0010_0100;
      tick();
      tick();
      chk("int_masked_case", {7'd0, bus.int_out}, 8'd1);
      ack_cycle(3'd5, 1'b0, 8'b0010_0000);
      eoi(1'b0, 3'd0, 1'b0);
      chk("nseoi_clear2", bus.isr, 8'h00);

      // Nesting: only a higher-priority request interrupts a serviced level.
      bus.imr = 8'h00;
      bus.irr = 8'b0000_0100;
      tick();
      tick();
      ack_cycle(3'd2, 1'b0, 8'b0000_0100);
      bus.irr = 8'b0000_0010;
      tick();
      tick();
      chk("int_higher_nests", {7'd0, bus.int_out}, 8'd1);
      bus.irr = 8'b0001_0000;
      tick();
      tick();
      chk("int_lower_blocked", {7'd0, bus.int_out}, 8'd0);
      bus.irr = 8'h00;
      eoi(1'b0, 3'd0, 1'b0);
      chk("nseoi_clear3", bus.isr, 8'h00);

      // Automatic rotating EOI makes level 3 lowest, so level 4 then wins.
      bus.aeoi   = 1'b1;
      bus.rotate = 1'b1;
      bus.irr    = 8'b0000_1000;
      tick();
      tick();
      chk("int_aeoi", {7'd0, bus.int_out}, 8'd1);
      ack_cycle(3'd3, 1'b0, 8'b0000_1000);
      chk("aeoi_isr_clear", bus.isr, 8'h00);
      bus.irr = 8'b0001_1000;
      tick();
      tick();
      ack_cycle(3'd4, 1'b0, 8'b0001_0000);
      chk("aeoi_isr_clear2", bus.isr, 8'h00);
      bus.aeoi   = 1'b0;
      bus.rotate = 1'b0;

      // Request withdrawn before the first fall gives a spurious level-7 vector.
      bus.irr = 8'b0000_0001;
      tick();
      tick();
      bus.irr = 8'h00;
      ack_cycle(3'd7, 1'b1, 8'h00);

      // Rotating specific EOI on level 7 restores the default order.
      eoi(1'b1, 3'd7, 1'b1);
      bus.irr = 8'b1000_0001;
      tick();
      tick();
      ack_cycle(3'd0, 1'b0, 8'b0000_0001);
      eoi(1'b1, 3'd0, 1'b0);
      chk("seoi_clear", bus.isr, 8'h00);

      // Reset in the middle of an acknowledge aborts it.
      bus.irr = 8'b0000_0001;
      tick();
      tick();
      clr_q.push_back(3'd0);
      bus.inta_n = 1'b0;
      tick();
      tick();
      bus.inta_n = 1'b1;
      tick();
      chk("isr_before_reset", bus.isr, 8'b0000_0001);
      reset   = 1'b1;
      bus.irr = 8'h00;
      tick();
      chk("midreset_outputs", {bus.int_out, bus.clear_valid, bus.data_oe, bus.inta_count, bus.clear_level}, 8'd0);
      chk("midreset_isr", bus.isr, 8'h00);
      chk("midreset_data", bus.data_out, 8'h00);
      reset      = 1'b0;
      tick();
      bus.inta_n = 1'b0;
      tick();
      chk("no_oe_after_reset", {7'd0, bus.data_oe}, 8'd0);
      bus.inta_n = 1'b1;
      repeat (3) tick();

      chk("clear_queue_empty", 8'(clr_q.size()), 8'd0);
      chk("vector_queue_empty", 8'(vec_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
